// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search engine.
// Holds the FSM state encoding and the comparator-flag sanity check.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    DONE,
    ERR
  } sar_state_t;

  // Wide enough for the largest supported hold (CMP_LAT = 3).
  localparam int HOLD_CNT_W = 2;

  // A healthy comparator asserts exactly one of its three flags.
  function automatic logic flags_onehot(input logic lesser, input logic greater,
                                        input logic equal);
    return ( lesser & ~greater & ~equal) |
           (~lesser &  greater & ~equal) |
           (~lesser & ~greater &  equal);
  endfunction

endpackage

// File: rtl/sar_hold_timer.sv
// Holds each trial for CMP_LAT extra cycles and strobes o_sample in the last
// hold cycle, so the flags are taken at the edge that ends that cycle.
module sar_hold_timer
  import sar_pkg::*;
#(
  parameter int CMP_LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_sample
);

  localparam logic [HOLD_CNT_W-1:0] LAT = HOLD_CNT_W'(CMP_LAT);

  logic [HOLD_CNT_W-1:0] r_cnt;

  assign o_sample = i_en && (r_cnt == LAT);

  // NOTE: state registers use non-blocking assignments so every flop in the
  // design updates from pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || o_sample) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + HOLD_CNT_W'(1);
    end
  end

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search: probes acc|(1<<bit) against an external
// comparator and recovers the target MSB-first in at most WIDTH probes.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CMP_LAT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         cmp_lesser,
  input  logic                         cmp_greater,
  input  logic                         cmp_equal,
  output logic [WIDTH-1:0]             trial,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH-1:0]             result,
  output logic                         found,
  output logic                         err,
  output logic [$clog2(WIDTH+1)-1:0]   steps
);

  localparam int BIT_W  = $clog2(WIDTH);
  localparam int STEP_W = $clog2(WIDTH+1);

  sar_state_t         r_state;
  logic [WIDTH-1:0]   r_acc;
  logic [BIT_W-1:0]   r_bit;

  logic               w_sample;
  logic               w_flags_ok;
  logic [WIDTH-1:0]   w_acc_next;
  logic [BIT_W-1:0]   w_bit_dec;
  logic [WIDTH-1:0]   w_trial_next;

  sar_hold_timer #(
    .CMP_LAT (CMP_LAT)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  ((r_state != PROBE) || abort),
    .i_en     (r_state == PROBE),
    .o_sample (w_sample)
  );

  // trial is always acc|(1<<bit), so a lesser verdict keeps it as the new acc.
  assign w_flags_ok   = flags_onehot(cmp_lesser, cmp_greater, cmp_equal);
  assign w_acc_next   = cmp_lesser ? trial : r_acc;
  assign w_bit_dec    = r_bit - BIT_W'(1);
  assign w_trial_next = w_acc_next | (WIDTH'(1) << w_bit_dec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_bit   <= BIT_W'(WIDTH-1);
      trial   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
      found   <= 1'b0;
      steps   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= PROBE;
            r_acc   <= '0;
            r_bit   <= BIT_W'(WIDTH-1);
            trial   <= {1'b1, {(WIDTH-1){1'b0}}};
            busy    <= 1'b1;
            found   <= 1'b0;
            steps   <= '0;
          end
        end
        PROBE: begin
          if (abort) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            trial   <= '0;
          end else if (w_sample) begin
            if (!w_flags_ok) begin
              r_state <= ERR;
              err     <= 1'b1;
              busy    <= 1'b0;
              trial   <= '0;
            end else begin
              steps <= steps + STEP_W'(1);
              if (cmp_equal) begin
                result  <= trial;
                found   <= 1'b1;
                r_state <= DONE;
                done    <= 1'b1;
                busy    <= 1'b0;
                trial   <= '0;
              end else if (r_bit == '0) begin
                result  <= w_acc_next;
                r_state <= DONE;
                done    <= 1'b1;
                busy    <= 1'b0;
                trial   <= '0;
              end else begin
                r_acc <= w_acc_next;
                r_bit <= w_bit_dec;
                trial <= w_trial_next;
              end
            end
          end
        end
        DONE, ERR: r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: two instances (CMP_LAT 0 and 2, WIDTH 8) against
// a closed-form search model, plus directed literal expectations.
module tb_sar_search_ctrl;

  localparam int K_DONE  = 0;
  localparam int K_ERR   = 1;
  localparam int K_ABORT = 2;

  typedef struct {
    bit         active;
    int         c0;
    int         lat;
    logic [7:0] tgt;
    int         end_k;
    int         kind;
    int         probes;
    logic [7:0] prior;
  } rec_t;

  typedef struct {
    logic [7:0] trial;
    logic       busy;
    logic       done;
    logic       err;
    logic       found;
    logic [7:0] result;
    logic [3:0] steps;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [2];
  logic       abort [2];
  logic       fb    [2];
  logic [7:0] tg    [2];
  logic       cl    [2];
  logic       cg    [2];
  logic       ce    [2];
  logic [7:0] trial [2];
  logic [7:0] result[2];
  logic       busy  [2];
  logic       done  [2];
  logic       found [2];
  logic       err   [2];
  logic [3:0] steps [2];

  rec_t rec[2];
  int   cyc;
  int   n_checks;
  int   n_err;

  always #5 clk = ~clk;

  sar_search_ctrl #(.WIDTH(8), .CMP_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .cmp_lesser(cl[0]), .cmp_greater(cg[0]), .cmp_equal(ce[0]),
    .trial(trial[0]), .busy(busy[0]), .done(done[0]), .result(result[0]),
    .found(found[0]), .err(err[0]), .steps(steps[0])
  );

  sar_search_ctrl #(.WIDTH(8), .CMP_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .cmp_lesser(cl[1]), .cmp_greater(cg[1]), .cmp_equal(ce[1]),
    .trial(trial[1]), .busy(busy[1]), .done(done[1]), .result(result[1]),
    .found(found[1]), .err(err[1]), .steps(steps[1])
  );

  // Comparator environment; fb forces an illegal greater+equal pattern.
  for (genvar g = 0; g < 2; g++) begin : g_cmp
    assign cl[g] = fb[g] ? 1'b0 : (trial[g] <  tg[g]);
    assign cg[g] = fb[g] ? 1'b1 : (trial[g] >  tg[g]);
    assign ce[g] = fb[g] ? 1'b1 : (trial[g] == tg[g]);
  end

  function automatic int lat_of(int i);
    return (i == 0) ? 0 : 2;
  endfunction

  // Probe n keeps the target's top n-1 bits and sets bit 8-n.
  function automatic logic [7:0] trial_of(logic [7:0] t, int n);
    logic [7:0] hi;
    logic [7:0] one;
    int         s;
    s   = 8 - n;
    hi  = 8'hFF;
    hi  = hi << (s + 1);
    one = 8'd1;
    return (t & hi) | (one << s);
  endfunction

  // The search stops at the probe that lands on the target's lowest set bit.
  function automatic int probes_for(logic [7:0] t);
    for (int b = 0; b < 8; b++) begin
      if (t[b]) return 8 - b;
    end
    return 8;
  endfunction

  function automatic exp_t model_out(rec_t r, int k);
    exp_t e;
    int   l1;
    e.trial  = '0;
    e.busy   = 1'b0;
    e.done   = 1'b0;
    e.err    = 1'b0;
    e.found  = 1'b0;
    e.result = '0;
    e.steps  = '0;
    if (!r.active) return e;
    l1       = r.lat + 1;
    e.result = r.prior;
    if (k < r.end_k) begin
      e.busy  = 1'b1;
      e.trial = trial_of(r.tgt, k / l1 + 1);
      e.steps = 4'(k / l1);
    end else begin
      case (r.kind)
        K_DONE: begin
          e.result = r.tgt;
          e.found  = (r.tgt != 8'h00);
          e.steps  = 4'(r.probes);
          e.done   = (k == r.end_k);
        end
        K_ERR: begin
          e.steps = 4'(r.end_k / l1 - 1);
          e.err   = (k == r.end_k);
        end
        default: e.steps = 4'((r.end_k - 1) / l1);
      endcase
    end
    return e;
  endfunction

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at t=%0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  int   m_kp;
  int   m_l1;
  int   m_cyc_n;
  exp_t m_e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) rec[i].active = 1'b0;
    end else begin
      m_cyc_n = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        m_kp = cyc - rec[i].c0;
        m_l1 = rec[i].lat + 1;
        if (rec[i].active && m_kp < rec[i].end_k) begin
          if (abort[i]) begin
            rec[i].kind  = K_ABORT;
            rec[i].end_k = m_kp + 1;
          end else if (fb[i] && ((m_kp + 1) % m_l1 == 0)) begin
            rec[i].kind  = K_ERR;
            rec[i].end_k = m_kp + 1;
          end
        end else if (start[i] && !(rec[i].active && m_kp == rec[i].end_k &&
                                   rec[i].kind != K_ABORT)) begin
          m_e           = model_out(rec[i], m_kp);
          rec[i].prior  = m_e.result;
          rec[i].active = 1'b1;
          rec[i].c0     = m_cyc_n;
          rec[i].lat    = lat_of(i);
          rec[i].tgt    = tg[i];
          rec[i].kind   = K_DONE;
          rec[i].probes = probes_for(tg[i]);
          rec[i].end_k  = rec[i].probes * (lat_of(i) + 1);
        end
      end
      cyc = m_cyc_n;
    end
  end

  exp_t c_e;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      c_e = model_out(rec[i], cyc - rec[i].c0);
      check("trial",  i, 32'(trial[i]),  32'(c_e.trial));
      check("busy",   i, 32'(busy[i]),   32'(c_e.busy));
      check("done",   i, 32'(done[i]),   32'(c_e.done));
      check("err",    i, 32'(err[i]),    32'(c_e.err));
      check("found",  i, 32'(found[i]),  32'(c_e.found));
      check("result", i, 32'(result[i]), 32'(c_e.result));
      check("steps",  i, 32'(steps[i]),  32'(c_e.steps));
    end
  end

  // Called at a negedge; returns at the negedge of probe cycle 0.
  task automatic start_search(input int i, input logic [7:0] t);
    tg[i]    = t;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  // Returns at the negedge of the done/err cycle; k is its cycle index.
  task automatic wait_end(input int i, input int k0, output int k);
    k = k0;
    while (!(done[i] || err[i]) && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("end_seen", i, 32'(done[i] | err[i]), 32'd1);
  endtask

  logic [7:0] t1_seq [8];
  int         k;

  initial begin
    t1_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    cyc = 0;
    n_checks = 0;
    n_err = 0;
    for (int i = 0; i < 2; i++) begin
      rec[i].active = 1'b0;
      rec[i].c0     = 0;
      start[i] = 1'b0;
      abort[i] = 1'b0;
      fb[i]    = 1'b0;
      tg[i]    = 8'h00;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_trial",  0, 32'(trial[0]),  32'h0);
    check("rst_busy",   0, 32'(busy[0]),   32'h0);
    check("rst_result", 1, 32'(result[1]), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // T1: 0xA5 with a combinational comparator.
    start_search(0, 8'hA5);
    for (int n = 0; n < 8; n++) begin
      check("t1_trial", 0, 32'(trial[0]), 32'(t1_seq[n]));
      @(negedge clk);
    end
    check("t1_done",   0, 32'(done[0]),   32'd1);
    check("t1_result", 0, 32'(result[0]), 32'hA5);
    check("t1_found",  0, 32'(found[0]),  32'd1);
    check("t1_steps",  0, 32'(steps[0]),  32'd8);
    @(negedge clk);

    // T2: single MSB target is hit on the first probe.
    start_search(0, 8'h80);
    check("t2_trial", 0, 32'(trial[0]), 32'h80);
    @(negedge clk);
    check("t2_done",   0, 32'(done[0]),   32'd1);
    check("t2_result", 0, 32'(result[0]), 32'h80);
    check("t2_steps",  0, 32'(steps[0]),  32'd1);
    @(negedge clk);

    // T3: boundary targets, plus a start during the done cycle.
    start_search(0, 8'h00);
    wait_end(0, 0, k);
    check("t3a_cycle",  0, 32'(k),         32'd8);
    check("t3a_result", 0, 32'(result[0]), 32'h00);
    check("t3a_found",  0, 32'(found[0]),  32'd0);
    check("t3a_steps",  0, 32'(steps[0]),  32'd8);
    @(negedge clk);
    start_search(0, 8'hFF);
    wait_end(0, 0, k);
    check("t3b_result", 0, 32'(result[0]), 32'hFF);
    check("t3b_found",  0, 32'(found[0]),  32'd1);
    check("t3b_steps",  0, 32'(steps[0]),  32'd8);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("start_in_done", 0, 32'(busy[0]), 32'd0);
    @(negedge clk);

    // T4: three-cycle hold per trial.
    start_search(1, 8'h3C);
    check("t4_hold0", 1, 32'(trial[1]), 32'h80);
    @(negedge clk);
    check("t4_hold1", 1, 32'(trial[1]), 32'h80);
    @(negedge clk);
    check("t4_hold2", 1, 32'(trial[1]), 32'h80);
    @(negedge clk);
    check("t4_probe2", 1, 32'(trial[1]), 32'h40);
    wait_end(1, 3, k);
    check("t4_cycle",  1, 32'(k),         32'd18);
    check("t4_result", 1, 32'(result[1]), 32'h3C);
    check("t4_steps",  1, 32'(steps[1]),  32'd6);
    @(negedge clk);
    start_search(1, 8'hFF);
    wait_end(1, 0, k);
    check("t4_worst_cycle", 1, 32'(k), 32'd24);
    @(negedge clk);

    // T5: illegal flags on probe 3; start while busy is ignored.
    start_search(0, 8'h5A);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    fb[0]    = 1'b1;
    @(negedge clk);
    fb[0] = 1'b0;
    check("t5_err",    0, 32'(err[0]),    32'd1);
    check("t5_done",   0, 32'(done[0]),   32'd0);
    check("t5_result", 0, 32'(result[0]), 32'hFF);
    check("t5_steps",  0, 32'(steps[0]),  32'd2);
    @(negedge clk);
    check("t5_idle", 0, 32'(busy[0]), 32'd0);

    // T6: abort at probe 4, then reset mid-search, then a clean search.
    start_search(0, 8'h77);
    repeat (3) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check("t6_abort_busy",   0, 32'(busy[0]),   32'd0);
    check("t6_abort_done",   0, 32'(done[0]),   32'd0);
    check("t6_abort_result", 0, 32'(result[0]), 32'hFF);
    check("t6_abort_steps",  0, 32'(steps[0]),  32'd3);
    start_search(0, 8'h33);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_trial",  0, 32'(trial[0]),  32'h0);
    check("t6_rst_busy",   0, 32'(busy[0]),   32'h0);
    check("t6_rst_result", 0, 32'(result[0]), 32'h0);
    check("t6_rst_steps",  0, 32'(steps[0]),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    start_search(0, 8'h33);
    wait_end(0, 0, k);
    check("t6_cycle",  0, 32'(k),         32'd8);
    check("t6_result", 0, 32'(result[0]), 32'h33);
    check("t6_found",  0, 32'(found[0]),  32'd1);
    check("t6_steps",  0, 32'(steps[0]),  32'd8);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
